// File: rtl/masku_result_queue.sv
// masku_result_queue
// Returns full-width mask-unit results to the lanes' VRF write ports. Each
// lane has a private FIFO, so lanes drain independently through req/gnt.
// Upstream is backpressured whenever any lane FIFO is full.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   result_*_i            upstream result word per lane, common addr/id, valid
//   result_ready_o        upstream ready (no lane FIFO full)
//   masku_result_*_o      per-lane FIFO head (data, be, addr, id)
//   masku_result_req_o    per-lane request (FIFO not empty)
//   masku_result_gnt_i    per-lane grant, pops the head
//   pending_o             total entries held across all lanes
//   idle_o                all FIFOs empty
module masku_result_queue #(
    parameter int unsigned NrLanes    = 4,
    parameter int unsigned Depth      = 2,
    parameter int unsigned IdWidth    = 3,
    parameter int unsigned Elen       = 64,
    parameter int unsigned VAddrWidth = 32,
    localparam int unsigned BeWidth   = Elen / 8,
    localparam int unsigned PendWidth = $clog2(NrLanes * Depth + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NrLanes-1:0][Elen-1:0]          result_i,
    input  logic [NrLanes-1:0][BeWidth-1:0]       result_be_i,
    input  logic [VAddrWidth-1:0]                 result_addr_i,
    input  logic [IdWidth-1:0]                    result_id_i,
    input  logic                                  result_valid_i,
    output logic                                  result_ready_o,
    output logic [NrLanes-1:0][Elen-1:0]          masku_result_o,
    output logic [NrLanes-1:0][BeWidth-1:0]       masku_result_be_o,
    output logic [NrLanes-1:0][VAddrWidth-1:0]    masku_result_addr_o,
    output logic [NrLanes-1:0][IdWidth-1:0]       masku_result_id_o,
    output logic [NrLanes-1:0]                    masku_result_req_o,
    input  logic [NrLanes-1:0]                    masku_result_gnt_i,
    output logic [PendWidth-1:0]                  pending_o,
    output logic                                  idle_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [NrLanes-1:0][CntWidth-1:0] w_count;
    logic [NrLanes-1:0]               w_full;
    logic                             w_accept;
    logic [PendWidth-1:0]             w_pending;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    // Ready depends only on registered counts: a same-cycle pop never frees a slot.
    assign result_ready_o = ~|w_full;
    assign w_accept       = result_valid_i & result_ready_o;

    for (genvar l = 0; l < NrLanes; l++) begin : g_lane
        logic [Elen-1:0]       r_data [Depth];
        logic [BeWidth-1:0]    r_be   [Depth];
        logic [VAddrWidth-1:0] r_addr [Depth];
        logic [IdWidth-1:0]    r_id   [Depth];
        logic [PtrWidth-1:0]   r_wr_ptr;
        logic [PtrWidth-1:0]   r_rd_ptr;
        logic [CntWidth-1:0]   r_count;
        logic                  w_push;
        logic                  w_pop;

        // Lanes with no enabled bytes have nothing to write back.
        assign w_push = w_accept & (|result_be_i[l]);
        assign w_pop  = (r_count != '0) & masku_result_gnt_i[l];

        // Lane FIFO storage, pointers and occupancy.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                for (int i = 0; i < Depth; i++) begin
                    r_data[PtrWidth'(i)] <= '0;
                    r_be[PtrWidth'(i)]   <= '0;
                    r_addr[PtrWidth'(i)] <= '0;
                    r_id[PtrWidth'(i)]   <= '0;
                end
            end else begin
                if (w_push) begin
                    r_data[r_wr_ptr] <= result_i[l];
                    r_be[r_wr_ptr]   <= result_be_i[l];
                    r_addr[r_wr_ptr] <= result_addr_i;
                    r_id[r_wr_ptr]   <= result_id_i;
                    r_wr_ptr         <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CntWidth'(1);
                    2'b01:   r_count <= r_count - CntWidth'(1);
                    default: r_count <= r_count;
                endcase
            end
        end

        assign w_count[l]             = r_count;
        assign w_full[l]              = (r_count >= CntWidth'(Depth));
        assign masku_result_req_o[l]  = (r_count != '0);
        assign masku_result_o[l]      = r_data[r_rd_ptr];
        assign masku_result_be_o[l]   = r_be[r_rd_ptr];
        assign masku_result_addr_o[l] = r_addr[r_rd_ptr];
        assign masku_result_id_o[l]   = r_id[r_rd_ptr];

        a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
            r_count <= CntWidth'(Depth));

        a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
            !(w_push && (r_count == CntWidth'(Depth))));

        a_head_stable: assert property (@(posedge clk_i) disable iff (rst_i)
            (masku_result_req_o[l] && !masku_result_gnt_i[l]) |=>
            $stable({masku_result_o[l], masku_result_be_o[l],
                     masku_result_addr_o[l], masku_result_id_o[l]}));
    end

    // Total occupancy across lanes.
    always_comb begin
        w_pending = '0;
        for (int l = 0; l < NrLanes; l++) begin
            w_pending = w_pending + PendWidth'(w_count[l]);
        end
    end

    assign pending_o = w_pending;
    assign idle_o    = (w_pending == '0);

endmodule

// File: tb/tb_masku_result_queue.sv
module tb_masku_result_queue;

    localparam int unsigned NrLanes    = 4;
    localparam int unsigned Depth      = 2;
    localparam int unsigned IdWidth    = 3;
    localparam int unsigned Elen       = 64;
    localparam int unsigned VAddrWidth = 32;
    localparam int unsigned BeWidth    = 8;
    localparam int unsigned PendWidth  = 4;

    typedef struct packed {
        logic [Elen-1:0]       data;
        logic [BeWidth-1:0]    be;
        logic [VAddrWidth-1:0] addr;
        logic [IdWidth-1:0]    id;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic [NrLanes-1:0][Elen-1:0]       result;
    logic [NrLanes-1:0][BeWidth-1:0]    be;
    logic [VAddrWidth-1:0]              addr;
    logic [IdWidth-1:0]                 id;
    logic                               valid;
    logic                               ready;
    logic [NrLanes-1:0][Elen-1:0]       m_result;
    logic [NrLanes-1:0][BeWidth-1:0]    m_be;
    logic [NrLanes-1:0][VAddrWidth-1:0] m_addr;
    logic [NrLanes-1:0][IdWidth-1:0]    m_id;
    logic [NrLanes-1:0]                 req;
    logic [NrLanes-1:0]                 gnt;
    logic [PendWidth-1:0]               pending;
    logic                               idle;

    ent_t sbq [NrLanes][$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    masku_result_queue #(
        .NrLanes(NrLanes), .Depth(Depth), .IdWidth(IdWidth),
        .Elen(Elen), .VAddrWidth(VAddrWidth)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .result_i           (result),
        .result_be_i        (be),
        .result_addr_i      (addr),
        .result_id_i        (id),
        .result_valid_i     (valid),
        .result_ready_o     (ready),
        .masku_result_o     (m_result),
        .masku_result_be_o  (m_be),
        .masku_result_addr_o(m_addr),
        .masku_result_id_o  (m_id),
        .masku_result_req_o (req),
        .masku_result_gnt_i (gnt),
        .pending_o          (pending),
        .idle_o             (idle)
    );

    // Record what each lane should eventually deliver for the word now driven.
    task automatic push_expect();
        for (int l = 0; l < NrLanes; l++) begin
            if (be[l] != '0) sbq[l].push_back({result[l], be[l], addr, id});
        end
    endtask

    task automatic new_word();
        for (int l = 0; l < NrLanes; l++) result[l] = {$urandom, $urandom};
        addr = $urandom;
        id   = IdWidth'($urandom);
    endtask

    // One clock: on the falling edge, every granted head is popped from the
    // scoreboard and compared; returns 1 time unit after the rising edge.
    task automatic advance();
        ent_t exp_e;
        ent_t got_e;
        @(negedge clk);
        for (int l = 0; l < NrLanes; l++) begin
            if (req[l] && gnt[l]) begin
                n_tests++;
                got_e = {m_result[l], m_be[l], m_addr[l], m_id[l]};
                if (sbq[l].size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_lane%0d: got unexpected entry %h required none", l, got_e);
                end else begin
                    exp_e = sbq[l].pop_front();
                    if (got_e !== exp_e) begin
                        n_fail++;
                        $display("FAIL sb_lane%0d: got %h required %h", l, got_e, exp_e);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; valid = 1'b0; gnt = '0; be = '0; result = '0; addr = '0; id = '0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (req !== 4'b0) begin n_fail++; $display("FAIL reset_req: got %b required 0000", req); end
        n_tests++; if (pending !== 4'd0) begin n_fail++; $display("FAIL reset_pending: got %0d required 0", pending); end
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b required 1", idle); end
        n_tests++; if ({m_result, m_be, m_addr, m_id} !== '0) begin n_fail++; $display("FAIL reset_heads: got %h required 0", {m_result, m_be, m_addr, m_id}); end
        rst = 1'b0;
        advance();
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", ready); end
    endtask

    task automatic test_single();
        gnt = 4'hF;
        result = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        be = {4{8'hFF}}; addr = 32'h10; id = 3'd2; valid = 1'b1;
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b required 1", ready); end
        n_tests++; if (req !== 4'b0) begin n_fail++; $display("FAIL single_nobypass: got %b required 0000", req); end
        push_expect();
        advance();
        valid = 1'b0;
        n_tests++; if (req !== 4'hF) begin n_fail++; $display("FAIL single_req: got %b required 1111", req); end
        n_tests++; if (pending !== 4'd4) begin n_fail++; $display("FAIL single_pending4: got %0d required 4", pending); end
        n_tests++; if (m_result[3] !== 64'h4444444444444444) begin n_fail++; $display("FAIL single_data3: got %h required 4444444444444444", m_result[3]); end
        n_tests++; if (m_addr[2] !== 32'h10 || m_id[1] !== 3'd2) begin n_fail++; $display("FAIL single_addr_id: got %h/%0d required 10/2", m_addr[2], m_id[1]); end
        advance();
        n_tests++; if (pending !== 4'd0 || idle !== 1'b1) begin n_fail++; $display("FAIL single_drained: got pending %0d idle %b required 0 1", pending, idle); end
    endtask

    task automatic test_partial();
        gnt = 4'h0;
        new_word();
        be = {8'h00, 8'h0F, 8'h00, 8'hFF}; valid = 1'b1;
        push_expect();
        advance();
        valid = 1'b0;
        n_tests++; if (req !== 4'b0101) begin n_fail++; $display("FAIL partial_req: got %b required 0101", req); end
        n_tests++; if (pending !== 4'd2) begin n_fail++; $display("FAIL partial_pending: got %0d required 2", pending); end
        n_tests++; if (m_be[0] !== 8'hFF || m_be[2] !== 8'h0F) begin n_fail++; $display("FAIL partial_be: got %h/%h required ff/0f", m_be[0], m_be[2]); end
        gnt = 4'hF;
        advance();
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL partial_idle: got %b required 1", idle); end
        // An accept with no enabled bytes anywhere must leave everything untouched.
        new_word(); be = '0; valid = 1'b1;
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL zero_be_ready: got %b required 1", ready); end
        advance();
        valid = 1'b0;
        n_tests++; if (pending !== 4'd0 || req !== 4'b0) begin n_fail++; $display("FAIL zero_be_state: got pending %0d req %b required 0 0000", pending, req); end
    endtask

    task automatic test_backpressure();
        gnt = 4'b0111; be = {4{8'hFF}}; valid = 1'b1;
        new_word();
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_w0: got %b required 1", ready); end
        push_expect(); advance();
        new_word();
        n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_w1: got %b required 1", ready); end
        push_expect(); advance();
        new_word();
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop: got %b required 0", ready); end
        n_tests++; if (pending !== 4'd5) begin n_fail++; $display("FAIL bp_pending5: got %0d required 5", pending); end
        advance();
        n_tests++; if (pending !== 4'd2 || req !== 4'b1000) begin n_fail++; $display("FAIL bp_others_drain: got pending %0d req %b required 2 1000", pending, req); end
        advance();
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_held: got %b required 0", ready); end
        gnt = 4'hF;
        n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_fallthrough: got %b required 0", ready); end
        advance();
        gnt = 4'b0111;
        n_tests++; if (ready !== 1'b1 || pending !== 4'd1) begin n_fail++; $display("FAIL bp_ready_back: got ready %b pending %0d required 1 1", ready, pending); end
        push_expect(); advance();
        valid = 1'b0;
        n_tests++; if (pending !== 4'd5) begin n_fail++; $display("FAIL bp_w2_pending: got %0d required 5", pending); end
        gnt = 4'hF;
        advance(); advance();
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got %b required 1", idle); end
    endtask

    task automatic test_full_pushpop();
        gnt = 4'h0; be = {8'h00, 8'h00, 8'hFF, 8'h00}; valid = 1'b1;
        new_word(); push_expect(); advance();
        new_word(); push_expect(); advance();
        new_word();
        gnt = 4'b0010;
        n_tests++; if (ready !== 1'b0 || pending !== 4'd2) begin n_fail++; $display("FAIL full_blocked: got ready %b pending %0d required 0 2", ready, pending); end
        advance();
        n_tests++; if (ready !== 1'b1 || pending !== 4'd1) begin n_fail++; $display("FAIL full_reopen: got ready %b pending %0d required 1 1", ready, pending); end
        push_expect(); advance();
        valid = 1'b0;
        n_tests++; if (pending !== 4'd1 || req !== 4'b0010) begin n_fail++; $display("FAIL full_pushpop: got pending %0d req %b required 1 0010", pending, req); end
        advance();
        n_tests++; if (idle !== 1'b1) begin n_fail++; $display("FAIL full_idle: got %b required 1", idle); end
    endtask

    task automatic test_streaming();
        int left;
        gnt = 4'hF;
        for (int w = 0; w < 16; w++) begin
            new_word();
            for (int l = 0; l < NrLanes; l++) be[l] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            valid = 1'b1;
            n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready_w%0d: got %b required 1", w, ready); end
            push_expect();
            advance();
        end
        valid = 1'b0;
        advance();
        left = 0;
        for (int l = 0; l < NrLanes; l++) left += sbq[l].size();
        n_tests++; if (left != 0) begin n_fail++; $display("FAIL stream_undelivered: got %0d left required 0", left); end
        n_tests++; if (idle !== 1'b1 || pending !== 4'd0) begin n_fail++; $display("FAIL stream_idle: got idle %b pending %0d required 1 0", idle, pending); end
    endtask

    task automatic test_reset_mid();
        gnt = 4'h0; new_word(); be = {8'h00, 8'hFF, 8'hFF, 8'hFF}; valid = 1'b1;
        push_expect(); advance();
        valid = 1'b0;
        n_tests++; if (pending !== 4'd3) begin n_fail++; $display("FAIL mid_held: got %0d required 3", pending); end
        #1 rst = 1'b1;
        #1;
        n_tests++; if (req !== 4'b0 || pending !== 4'd0 || idle !== 1'b1) begin n_fail++; $display("FAIL mid_async: got req %b pending %0d idle %b required 0000 0 1", req, pending, idle); end
        for (int l = 0; l < NrLanes; l++) sbq[l].delete();
        @(posedge clk); #1;
        rst = 1'b0;
        advance();
        n_tests++; if (ready !== 1'b1 || {m_result, m_be, m_addr, m_id} !== '0) begin n_fail++; $display("FAIL mid_release: got ready %b heads %h required 1 0", ready, {m_result, m_be, m_addr, m_id}); end
        gnt = 4'hF;
        advance(); advance();
        n_tests++; if (req !== 4'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL mid_quiet: got req %b idle %b required 0000 1", req, idle); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_partial();
        test_backpressure();
        test_full_pushpop();
        test_streaming();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
